// File: rtl/data_cache_ctrl.sv
// Data cache controller: tag/valid sweep after reset, lookup of CPU accesses,
// blocking line refill on load misses, write-no-allocate stores, and a
// one-cycle index-invalidate cache operation. Every output is a flop, so each
// state's strobes are scheduled on the edge that enters that state.
module data_cache_ctrl #(
  parameter int INDEX_W    = 7,
  parameter int TAG_W      = 20,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cpu_req,
  input  logic                          cpu_wr,
  input  logic [31:0]                   cpu_addr,
  output logic                          cpu_addr_ok,
  output logic                          cpu_data_ok,
  output logic                          hit_we,
  input  logic                          cacheop_req,
  input  logic [INDEX_W-1:0]            cacheop_index,
  output logic                          cacheop_ack,
  output logic                          tagv_en,
  output logic                          tagv_wen,
  output logic                          tagv_op_wen,
  output logic [INDEX_W-1:0]            tagv_index,
  output logic [TAG_W-1:0]              tagv_tag_wdata,
  output logic                          tagv_valid_wdata,
  input  logic                          tagv_hit,
  output logic                          rd_req,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_rdy,
  input  logic                          ret_valid,
  input  logic                          ret_last,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word
);

  // Byte address layout: {tag, index, word-in-line, byte-in-word}.
  // TAG_W + INDEX_W + OFF_W is expected to total 32.
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MISS,
    REFILL,
    UPDATE,
    OP
  } state_t;

  state_t             state;
  logic [INDEX_W-1:0] init_cnt;
  logic [WORD_W-1:0]  beat_cnt;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               req_wr;
  logic               lookup_wait;

  // The line offset selects the word inside the data RAM, which is addressed
  // outside this controller; only the tag and index matter here.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[OFF_W-1:0];

  // Single state machine; strobes default low each cycle and are raised only
  // on the edge entering the state that owns them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= INIT;
      init_cnt         <= '0;
      beat_cnt         <= '0;
      req_index        <= '0;
      req_tag          <= '0;
      req_wr           <= 1'b0;
      lookup_wait      <= 1'b0;
      cpu_addr_ok      <= 1'b0;
      cpu_data_ok      <= 1'b0;
      hit_we           <= 1'b0;
      cacheop_ack      <= 1'b0;
      tagv_en          <= 1'b0;
      tagv_wen         <= 1'b0;
      tagv_op_wen      <= 1'b0;
      tagv_index       <= '0;
      tagv_tag_wdata   <= '0;
      tagv_valid_wdata <= 1'b0;
      rd_req           <= 1'b0;
      rd_addr          <= '0;
      refill_we        <= 1'b0;
      refill_word      <= '0;
    end else begin
      cpu_addr_ok      <= 1'b0;
      cpu_data_ok      <= 1'b0;
      hit_we           <= 1'b0;
      cacheop_ack      <= 1'b0;
      tagv_en          <= 1'b0;
      tagv_wen         <= 1'b0;
      tagv_op_wen      <= 1'b0;
      tagv_valid_wdata <= 1'b0;
      refill_we        <= 1'b0;

      case (state)
        INIT: begin
          tagv_op_wen    <= 1'b1;
          tagv_index     <= init_cnt;
          tagv_tag_wdata <= '0;
          init_cnt       <= init_cnt + 1'b1;
          if (&init_cnt) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (cacheop_req) begin
            tagv_op_wen    <= 1'b1;
            tagv_index     <= cacheop_index;
            tagv_tag_wdata <= '0;
            cacheop_ack    <= 1'b1;
            state          <= OP;
          end else if (cpu_req) begin
            cpu_addr_ok    <= 1'b1;
            tagv_en        <= 1'b1;
            tagv_index     <= cpu_addr[OFF_W +: INDEX_W];
            tagv_tag_wdata <= cpu_addr[OFF_W+INDEX_W +: TAG_W];
            req_index      <= cpu_addr[OFF_W +: INDEX_W];
            req_tag        <= cpu_addr[OFF_W+INDEX_W +: TAG_W];
            req_wr         <= cpu_wr;
            lookup_wait    <= 1'b1;
            state          <= LOOKUP;
          end
        end

        LOOKUP: begin
          // The tag RAM answers one cycle after the index is presented, so
          // the first LOOKUP cycle only waits for tagv_hit to become valid.
          if (lookup_wait) begin
            lookup_wait <= 1'b0;
          end else if (tagv_hit) begin
            cpu_data_ok <= 1'b1;
            hit_we      <= req_wr;
            state       <= IDLE;
          end else if (req_wr) begin
            cpu_data_ok <= 1'b1;
            state       <= IDLE;
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= {req_tag, req_index, {OFF_W{1'b0}}};
            state   <= MISS;
          end
        end

        MISS: begin
          if (rd_rdy) begin
            rd_req   <= 1'b0;
            beat_cnt <= '0;
            state    <= REFILL;
          end
        end

        REFILL: begin
          if (ret_valid) begin
            refill_we   <= 1'b1;
            refill_word <= beat_cnt;
            beat_cnt    <= beat_cnt + 1'b1;
            if (ret_last) begin
              tagv_en          <= 1'b1;
              tagv_wen         <= 1'b1;
              tagv_index       <= req_index;
              tagv_tag_wdata   <= req_tag;
              tagv_valid_wdata <= 1'b1;
              cpu_data_ok      <= 1'b1;
              state            <= UPDATE;
            end
          end
        end

        UPDATE: begin
          state <= IDLE;
        end

        OP: begin
          state <= IDLE;
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 7, meaning tagv set-index width.
REQ-002 SHALL have parameter TAG_W, default 20, meaning tag width; TAG_W+INDEX_W+2+log2(LINE_WORDS) SHALL equal 32.
REQ-003 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per line.
REQ-004 SHALL have ports, one clock and synchronous active-low reset:
  clk  in  1  clock, all logic on rising edge
  resetn  in  1  synchronous active-low reset
  cpu_req  in  1  CPU access request
  cpu_wr  in  1  1=store, 0=load
  cpu_addr  in  32  physical byte address
  cpu_addr_ok  out  1  request accepted this cycle
  cpu_data_ok  out  1  access complete, one-cycle pulse
  hit_we  out  1  store hit, data RAM write strobe
  cacheop_req  in  1  index-invalidate request
  cacheop_index  in  INDEX_W  set to invalidate
  cacheop_ack  out  1  invalidate done, one-cycle pulse
  tagv_en  out  1  tagv access enable
  tagv_wen  out  1  tagv refill write
  tagv_op_wen  out  1  tagv invalidate/init write
  tagv_index  out  INDEX_W  tagv index
  tagv_tag_wdata  out  TAG_W  tag to write/compare
  tagv_valid_wdata  out  1  valid bit to write
  tagv_hit  in  1  tag match and valid, one cycle after index
  rd_req  out  1  line-fill read request
  rd_addr  out  32  line-aligned fill address
  rd_rdy  in  1  memory accepts rd_req
  ret_valid  in  1  fill beat valid
  ret_last  in  1  final fill beat
  refill_we  out  1  data RAM refill word strobe
  refill_word  out  log2(LINE_WORDS)  refill word offset

Function
REQ-005 SHALL implement states INIT, IDLE, LOOKUP, MISS, REFILL, UPDATE, OP.
REQ-006 SHALL, in INIT, sweep index 0..2^INDEX_W-1 one per cycle with tagv_op_wen=1, tagv_valid_wdata=0, tag 0; after last index go IDLE (2^INDEX_W cycles).
REQ-007 SHALL hold cpu_addr_ok=0 and cacheop_ack=0 outside IDLE.
REQ-008 SHALL, in IDLE with cacheop_req=1, go OP; cacheop SHALL have priority over cpu_req, with cpu_addr_ok=0 that cycle.
REQ-009 SHALL, in OP, drive tagv_op_wen=1, tagv_index=cacheop_index (latched), tagv_valid_wdata=0, pulse cacheop_ack, return IDLE: 1-cycle op.
REQ-010 SHALL, in IDLE with cpu_req=1 and no cacheop_req, assert cpu_addr_ok, tagv_en=1, tagv_index/tagv_tag_wdata from cpu_addr, latch addr and wr, go LOOKUP.
REQ-011 SHALL, in LOOKUP on tagv_hit=1, pulse cpu_data_ok, and hit_we if store, then go IDLE; hit latency is 2 cycles from acceptance.
REQ-012 SHALL, in LOOKUP on miss with store, pulse cpu_data_ok, hit_we=0 (write-no-allocate), go IDLE.
REQ-013 SHALL, in LOOKUP on miss with load, go MISS.
REQ-014 SHALL, in MISS, hold rd_req=1, rd_addr={tag,index,0s}, stable until rd_rdy=1, then go REFILL.
REQ-015 SHALL, in REFILL, per ret_valid beat assert refill_we with refill_word=beat counter (from 0), increment counter; on ret_valid&ret_last go UPDATE.
REQ-016 SHALL ignore ret_valid outside REFILL; counter wraps modulo LINE_WORDS.
REQ-017 SHALL, in UPDATE, drive tagv_wen=1, tagv_en=1, latched index and tag, tagv_valid_wdata=1, pulse cpu_data_ok, go IDLE.
REQ-018 SHALL keep tagv_wen and tagv_op_wen never both 1; all strobes 0 unless stated.

Reset
REQ-019 SHALL, on resetn=0 at a rising edge, enter INIT, clear beat counter and latches, drive all outputs 0 next cycle, abandoning any MISS/REFILL in progress.
REQ-020 SHALL restart the full INIT sweep at index 0 if reset reasserts during INIT.

Verification
REQ-021 Reset release, INDEX_W=7 -> 128 cycles tagv_op_wen=1 indices 0..127, then cpu_addr_ok=1 on first cpu_req.
REQ-022 Load 0x0000_1040 after init -> miss, rd_addr=0x0000_1040, 8 beats refill_word 0..7, tagv_wen with index 0x02 tag 0x00001, cpu_data_ok; repeat load -> cpu_data_ok 2 cycles after accept, no rd_req.
REQ-023 Store to cached 0x0000_1044 -> hit_we=1 and cpu_data_ok same cycle; store to uncached line -> cpu_data_ok, no rd_req, no hit_we.
REQ-024 cacheop_req index 0x02 with cpu_req same cycle -> cacheop_ack next cycle, cpu_addr_ok delayed; subsequent load 0x0000_1040 misses.
REQ-025 rd_rdy held 0 for 5 cycles -> rd_req and rd_addr stable; resetn=0 during beat 3 of refill -> INIT, later beats ignored, no tagv_wen.
